fifo_ctrl_fsm: RTL

- Main control state machine for the FIFO-switch datapath.
- Sequences RESET -> INIT -> IDLE/ACTIVE/ERROR and latches the almost-full and almost-empty thresholds during INIT.
- Drives the "idle" qualifier consumed by the pop-counter block.
- Contains a readout sequencer that, on request while IDLE, walks counter indices 0..4 via the counter's req/idx interface and streams the captured counts out.

---
 rtl/fifo_ctrl_fsm.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fifo_ctrl_fsm.sv
// FIFO-switch main controller: RESET/INIT/IDLE/ACTIVE/ERROR sequencing,
// threshold latching, and a counter readout sequencer.
module fifo_ctrl_fsm #(
    parameter int                TH_W       = 3,
    parameter logic [TH_W-1:0]   AF_DEFAULT = 3'd6,
    parameter logic [TH_W-1:0]   AE_DEFAULT = 3'd1,
    parameter int                NUM_CNT    = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            init,
    input  logic [TH_W-1:0] af_thresh_in,
    input  logic [TH_W-1:0] ae_thresh_in,
    input  logic [4:0]      fifo_empty,
    input  logic [4:0]      fifo_error,
    input  logic            dump_req,
    input  logic            cnt_valid,
    input  logic [5:0]      cnt_data,
    output logic [4:0]      state,
    output logic            idle,
    output logic [TH_W-1:0] af_thresh,
    output logic [TH_W-1:0] ae_thresh,
    output logic            cfg_err,
    output logic            cnt_req,
    output logic [2:0]      cnt_idx,
    output logic            dump_busy,
    output logic            dump_valid,
    output logic [2:0]      dump_idx,
    output logic [5:0]      dump_data,
    output logic            dump_done,
    output logic            dump_abort
);

    typedef enum logic [4:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_e;

    typedef enum logic {
        SEQ_IDLE,
        SEQ_RUN
    } seq_e;

    localparam logic [2:0] LAST_IDX = 3'(NUM_CNT - 1);

    state_e          state_q, state_d;
    logic [TH_W-1:0] af_q, af_d;
    logic [TH_W-1:0] ae_q, ae_d;
    logic            cfg_err_q, cfg_err_d;

    seq_e            seq_q, seq_d;
    logic [2:0]      idx_q, idx_d;
    logic            dv_q, dv_d;
    logic            done_q, done_d;
    logic            abort_q, abort_d;
    logic [2:0]      didx_q, didx_d;
    logic [5:0]      ddata_q, ddata_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RESET;
            af_q      <= AF_DEFAULT;
            ae_q      <= AE_DEFAULT;
            cfg_err_q <= 1'b0;
            seq_q     <= SEQ_IDLE;
            idx_q     <= '0;
            dv_q      <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            didx_q    <= '0;
            ddata_q   <= '0;
        end else begin
            state_q   <= state_d;
            af_q      <= af_d;
            ae_q      <= ae_d;
            cfg_err_q <= cfg_err_d;
            seq_q     <= seq_d;
            idx_q     <= idx_d;
            dv_q      <= dv_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            didx_q    <= didx_d;
            ddata_q   <= ddata_d;
        end
    end

    // Main FSM; errors are not monitored while configuring
    always_comb begin
        state_d   = state_q;
        af_d      = af_q;
        ae_d      = ae_q;
        cfg_err_d = cfg_err_q;
        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                if (ae_thresh_in < af_thresh_in) begin
                    af_d = af_thresh_in;
                    ae_d = ae_thresh_in;
                end else begin
                    cfg_err_d = 1'b1;
                end
                state_d = init ? ST_INIT : ST_IDLE;
            end
            ST_IDLE: begin
                if (|fifo_error)              state_d = ST_ERROR;
                else if (init)                state_d = ST_INIT;
                else if (fifo_empty != 5'h1f) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (|fifo_error)              state_d = ST_ERROR;
                else if (init)                state_d = ST_INIT;
                else if (&fifo_empty)         state_d = ST_IDLE;
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_RESET;
        endcase
    end

    // Readout sequencer; any missing answer or loss of IDLE cancels the dump
    always_comb begin
        seq_d   = seq_q;
        idx_d   = idx_q;
        dv_d    = 1'b0;
        done_d  = 1'b0;
        abort_d = 1'b0;
        didx_d  = didx_q;
        ddata_d = ddata_q;
        case (seq_q)
            SEQ_IDLE: begin
                if (dump_req && state_q == ST_IDLE) begin
                    seq_d = SEQ_RUN;
                    idx_d = '0;
                end
            end
            SEQ_RUN: begin
                if (idle && cnt_valid) begin
                    dv_d    = 1'b1;
                    didx_d  = idx_q;
                    ddata_d = cnt_data;
                    if (idx_q == LAST_IDX) begin
                        done_d = 1'b1;
                        seq_d  = SEQ_IDLE;
                        idx_d  = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    abort_d = 1'b1;
                    seq_d   = SEQ_IDLE;
                    idx_d   = '0;
                end
            end
            default: seq_d = SEQ_IDLE;
        endcase
    end

    assign state      = state_q;
    assign idle       = (state_q == ST_IDLE);
    assign af_thresh  = af_q;
    assign ae_thresh  = ae_q;
    assign cfg_err    = cfg_err_q;
    assign dump_busy  = (seq_q == SEQ_RUN);
    assign cnt_req    = (seq_q == SEQ_RUN);
    assign cnt_idx    = idx_q;
    assign dump_valid = dv_q;
    assign dump_idx   = didx_q;
    assign dump_data  = ddata_q;
    assign dump_done  = done_q;
    assign dump_abort = abort_q;

endmodule
